// File: rtl/watch_hms.sv
// watch_hms: HH:MM:SS time-of-day counter with button-driven set mode and decimal-point edit mask.
// Optional alarm mode and alarm match flag are enabled by defining WATCH_ALARM_EN.
module watch_hms #(
  parameter int HOUR_MAX = 23,
  parameter int MIN_MAX  = 59,
  parameter int SEC_MAX  = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_up,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [5:0] o_hour,
  output logic [5:0] o_dp,
  output logic [1:0] o_mode,
  output logic       o_day_pulse,
  output logic       o_alarm
);
  localparam logic [5:0] HM = 6'(HOUR_MAX);
  localparam logic [5:0] MM = 6'(MIN_MAX);
  localparam logic [5:0] SM = 6'(SEC_MAX);
`ifdef WATCH_ALARM_EN
  typedef enum logic [1:0] {RUN = 2'd0, SET = 2'd1, ALARM = 2'd2} mode_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, SET = 2'd1} mode_t;
`endif
  typedef enum logic [1:0] {P_SEC = 2'd0, P_MIN = 2'd1, P_HOUR = 2'd2} pos_t;
  mode_t mode, mode_n;
  pos_t pos, pos_n;
  logic [5:0] sec, min, hour, sec_n, min_n, hour_n;
  logic [5:0] sec_o, min_o, hour_o, dp_n;
  logic prev_mode, prev_pos, prev_up, e_mode, e_pos, e_up, tick_en, day_n, alarm_n;
`ifdef WATCH_ALARM_EN
  logic [5:0] alarm_min, alarm_hour, alarm_min_n, alarm_hour_n;
`endif
  function automatic logic [5:0] inc(input logic [5:0] v, input logic [5:0] m);
    return v == m ? 6'd0 : v + 6'd1;
  endfunction
  always_comb begin
    e_mode = i_sw_mode & ~prev_mode;
    e_pos = i_sw_pos & ~prev_pos;
    e_up = i_sw_up & ~prev_up;
    tick_en = i_tick & (mode != SET);
    mode_n = mode;
    pos_n = pos;
    sec_n = sec;
    min_n = min;
    hour_n = hour;
    day_n = 1'b0;
`ifdef WATCH_ALARM_EN
    alarm_min_n = alarm_min;
    alarm_hour_n = alarm_hour;
`endif
    if (tick_en) begin
      sec_n = inc(sec, SM);
      min_n = sec == SM ? inc(min, MM) : min;
      hour_n = (sec == SM && min == MM) ? inc(hour, HM) : hour;
      day_n = sec == SM && min == MM && hour == HM;
    end
    // a mode edge swallows any pos/up edge arriving in the same cycle
    if (e_mode) begin
`ifdef WATCH_ALARM_EN
      mode_n = mode == RUN ? SET : mode == SET ? ALARM : RUN;
      pos_n = mode == SET ? P_MIN : P_SEC;
`else
      mode_n = mode == RUN ? SET : RUN;
      pos_n = P_SEC;
`endif
    end else if (mode == SET) begin
      if (e_up && pos == P_SEC) sec_n = inc(sec, SM);
      if (e_up && pos == P_MIN) min_n = inc(min, MM);
      if (e_up && pos == P_HOUR) hour_n = inc(hour, HM);
      if (e_pos) pos_n = pos == P_SEC ? P_MIN : pos == P_MIN ? P_HOUR : P_SEC;
    end
`ifdef WATCH_ALARM_EN
    else if (mode == ALARM) begin
      if (e_up && pos == P_HOUR) alarm_hour_n = inc(alarm_hour, HM);
      if (e_up && pos != P_HOUR) alarm_min_n = inc(alarm_min, MM);
      if (e_pos) pos_n = pos == P_HOUR ? P_MIN : P_HOUR;
    end
    alarm_n = mode_n == RUN && hour_n == alarm_hour_n && min_n == alarm_min_n;
    sec_o = mode_n == ALARM ? 6'd0 : sec_n;
    min_o = mode_n == ALARM ? alarm_min_n : min_n;
    hour_o = mode_n == ALARM ? alarm_hour_n : hour_n;
`else
    alarm_n = 1'b0;
    sec_o = sec_n;
    min_o = min_n;
    hour_o = hour_n;
`endif
    dp_n = mode_n == RUN ? 6'b000000 : pos_n == P_SEC ? 6'b000011 : pos_n == P_MIN ? 6'b001100 : 6'b110000;
  end
  always_ff @(posedge clk) begin
    prev_mode <= i_sw_mode;
    prev_pos <= i_sw_pos;
    prev_up <= i_sw_up;
    if (!rst_n) begin
      mode <= RUN;
      pos <= P_SEC;
      sec <= '0;
      min <= '0;
      hour <= '0;
      o_sec <= '0;
      o_min <= '0;
      o_hour <= '0;
      o_dp <= '0;
      o_mode <= '0;
      o_day_pulse <= 1'b0;
      o_alarm <= 1'b0;
`ifdef WATCH_ALARM_EN
      alarm_min <= '0;
      alarm_hour <= '0;
`endif
    end else begin
      mode <= mode_n;
      pos <= pos_n;
      sec <= sec_n;
      min <= min_n;
      hour <= hour_n;
      o_sec <= sec_o;
      o_min <= min_o;
      o_hour <= hour_o;
      o_dp <= dp_n;
      o_mode <= mode_n;
      o_day_pulse <= day_n;
      o_alarm <= alarm_n;
`ifdef WATCH_ALARM_EN
      alarm_min <= alarm_min_n;
      alarm_hour <= alarm_hour_n;
`endif
    end
  end
endmodule

// File: tb/tb_watch_hms.sv
// tb_watch_hms: directed self-checking bench for watch_hms.
module tb_watch_hms;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_tick = 1'b0;
  logic i_sw_mode = 1'b0;
  logic i_sw_pos = 1'b0;
  logic i_sw_up = 1'b0;
  logic [5:0] o_sec, o_min, o_hour, o_dp;
  logic [1:0] o_mode;
  logic o_day_pulse, o_alarm;
  int total = 0;
  int bad = 0;
  watch_hms dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_tick(i_tick),
    .i_sw_mode(i_sw_mode),
    .i_sw_pos(i_sw_pos),
    .i_sw_up(i_sw_up),
    .o_sec(o_sec),
    .o_min(o_min),
    .o_hour(o_hour),
    .o_dp(o_dp),
    .o_mode(o_mode),
    .o_day_pulse(o_day_pulse),
    .o_alarm(o_alarm)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic tick();
    i_tick = 1'b1;
    cyc(1);
    i_tick = 1'b0;
    cyc(1);
  endtask
  task automatic press_mode();
    i_sw_mode = 1'b1;
    cyc(1);
    i_sw_mode = 1'b0;
    cyc(1);
  endtask
  task automatic press_pos();
    i_sw_pos = 1'b1;
    cyc(1);
    i_sw_pos = 1'b0;
    cyc(1);
  endtask
  task automatic press_up(input int n);
    repeat (n) begin
      i_sw_up = 1'b1;
      cyc(1);
      i_sw_up = 1'b0;
      cyc(1);
    end
  endtask
  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, int'(o_hour), h);
    chk({tag, "_min"}, int'(o_min), m);
    chk({tag, "_sec"}, int'(o_sec), s);
  endtask
  initial begin
    cyc(2);
    chk_time("reset", 0, 0, 0);
    chk("reset_dp", int'(o_dp), 0);
    chk("reset_mode", int'(o_mode), 0);
    chk("reset_day", int'(o_day_pulse), 0);
    chk("reset_alarm", int'(o_alarm), 0);
    rst_n = 1'b1;
    cyc(1);
    repeat (61) tick();
    chk_time("t61", 0, 1, 1);
    chk("t61_dp", int'(o_dp), 0);
    chk("t61_mode", int'(o_mode), 0);
    press_mode();
    chk("set_mode", int'(o_mode), 1);
    chk("set_dp_sec", int'(o_dp), 6'b000011);
    press_up(57);
    press_pos();
    press_up(58);
    press_pos();
    press_up(23);
    chk_time("preload", 23, 59, 58);
    chk("preload_dp_hour", int'(o_dp), 6'b110000);
    press_mode();
    chk("run_mode", int'(o_mode), 0);
    chk("run_dp", int'(o_dp), 0);
    tick();
    chk_time("t_2359", 23, 59, 59);
    chk("day_early", int'(o_day_pulse), 0);
    i_tick = 1'b1;
    cyc(1);
    i_tick = 1'b0;
    chk_time("wrap", 0, 0, 0);
    chk("day_pulse", int'(o_day_pulse), 1);
    cyc(1);
    chk("day_clear", int'(o_day_pulse), 0);
    press_mode();
    press_pos();
    press_pos();
    press_up(5);
    press_pos();
    press_pos();
    press_up(59);
    chk("min59", int'(o_min), 59);
    press_up(1);
    chk("min_wrap", int'(o_min), 0);
    chk("min_wrap_hour", int'(o_hour), 5);
    chk("dp_min", int'(o_dp), 6'b001100);
    repeat (5) tick();
    chk("frozen_sec", int'(o_sec), 0);
    i_sw_up = 1'b1;
    cyc(100);
    i_sw_up = 1'b0;
    cyc(1);
    chk("hold_up", int'(o_min), 1);
    i_sw_mode = 1'b1;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    chk("held_mode", int'(o_mode), 0);
    chk_time("held_rst", 0, 0, 0);
    i_sw_mode = 1'b0;
    cyc(1);
    chk("held_mode_rel", int'(o_mode), 0);
    repeat (3) tick();
    i_sw_mode = 1'b1;
    i_sw_up = 1'b1;
    cyc(1);
    i_sw_mode = 1'b0;
    i_sw_up = 1'b0;
    chk("mode_up_mode", int'(o_mode), 1);
    chk("mode_up_dp", int'(o_dp), 6'b000011);
    chk("mode_up_sec", int'(o_sec), 3);
    cyc(1);
    press_up(1);
    chk("pos_is_sec", int'(o_sec), 4);
    press_mode();
    i_tick = 1'b1;
    i_sw_mode = 1'b1;
    cyc(1);
    i_tick = 1'b0;
    i_sw_mode = 1'b0;
    chk("tick_to_set_sec", int'(o_sec), 5);
    chk("tick_to_set_mode", int'(o_mode), 1);
    cyc(1);
    i_tick = 1'b1;
    i_sw_mode = 1'b1;
    cyc(1);
    i_tick = 1'b0;
    i_sw_mode = 1'b0;
    chk("tick_to_run_sec", int'(o_sec), 5);
    chk("tick_to_run_mode", int'(o_mode), 0);
    cyc(1);
    press_mode();
    i_sw_pos = 1'b1;
    i_sw_up = 1'b1;
    cyc(1);
    i_sw_pos = 1'b0;
    i_sw_up = 1'b0;
    chk("pos_up_sec", int'(o_sec), 6);
    chk("pos_up_dp", int'(o_dp), 6'b001100);
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("midedit_mode", int'(o_mode), 0);
    chk("midedit_dp", int'(o_dp), 0);
    chk_time("midedit", 0, 0, 0);
`ifdef WATCH_ALARM_EN
    press_mode();
    press_mode();
    chk("alarm_mode", int'(o_mode), 2);
    chk("alarm_dp_min", int'(o_dp), 6'b001100);
    press_up(2);
    chk_time("alarm_view", 0, 2, 0);
    press_pos();
    chk("alarm_dp_hour", int'(o_dp), 6'b110000);
    press_mode();
    chk("alarm_back_run", int'(o_mode), 0);
    chk_time("alarm_run", 0, 0, 0);
    for (int t = 1; t <= 181; t++) begin
      tick();
      chk($sformatf("alarm_t%0d", t), int'(o_alarm), (t >= 120 && t < 180) ? 1 : 0);
    end
    chk_time("alarm_end", 0, 3, 1);
`else
    repeat (3) press_mode();
    chk("no_alarm_mode", int'(o_mode), 1);
    chk("no_alarm_flag", int'(o_alarm), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/watch_hms.md
Name: watch_hms

Overview:
Time-of-day counter (HH:MM:SS) with button-driven set mode. It sits directly upstream of the two-digit separation, segment decode and six-digit scan display stages.
- Advances one second per i_tick pulse and outputs binary hour, minute and second fields, each split downstream into two BCD digits.
- Outputs a six-bit decimal-point mask that marks the field being edited in set mode.
- Single clock domain: time advances on a tick enable, never on a generated clock.

Parameters:
HOUR_MAX, 23, last hour value before wrap to 0 (11 gives a 0–11 clock)
MIN_MAX, 59, last minute value before wrap
SEC_MAX, 59, last second value before wrap

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  reset; one clock, synchronous, active-low
i_tick  input  1  one-clk-wide pulse at 1 Hz
i_sw_mode  input  1  debounced mode button, level, active-high
i_sw_pos  input  1  debounced field-select button, level, active-high
i_sw_up  input  1  debounced increment button, level, active-high
o_sec  output  6  seconds, 0..SEC_MAX
o_min  output  6  minutes, 0..MIN_MAX
o_hour  output  6  hours, 0..HOUR_MAX
o_dp  output  6  decimal-point mask; bit0 = rightmost digit
o_mode  output  2  0 = RUN, 1 = SET, 2 = ALARM
o_day_pulse  output  1  one-clk pulse on wrap from max time to 00:00:00
o_alarm  output  1  alarm match flag

Behaviour:
- Reset (rst_n low at posedge clk): sec = min = hour = 0, mode = RUN, pos = SEC, o_dp = 0, o_day_pulse = 0, o_alarm = 0.
- Button edge detect: each button has a prev register. During reset, prev <= current input, so a button held through reset produces no edge. Edge = input & ~prev. All button actions use edges only; holding a button gives one action.
- Mode FSM without WATCH_ALARM_EN: RUN -> SET on mode edge; SET -> RUN on mode edge.
- Entering SET forces pos = SEC. Leaving SET keeps the edited time values.
- RUN:
  - i_tick sampled at posedge with registered mode == RUN: sec + 1.
  - sec == SEC_MAX: sec = 0, min + 1.
  - min == MIN_MAX as well: min = 0, hour + 1.
  - hour == HOUR_MAX as well: hour = 0, and o_day_pulse = 1 for exactly that cycle.
  - Outputs update the cycle after the tick (one-clk latency).
  - pos and up edges are ignored.
- SET:
  - i_tick ignored; time is frozen.
  - pos edge cycles SEC -> MIN -> HOUR -> SEC.
  - up edge increments the selected field modulo (MAX+1) with no carry into other fields. Example: sec 59 -> 0, min unchanged.
- Simultaneous events:
  - Tick is gated by the mode at cycle start. A tick coincident with a RUN->SET mode edge is applied; one coincident with a SET->RUN edge is ignored.
  - Mode edge has priority over pos/up edges in the same cycle; the latter are dropped.
  - pos and up edges in the same cycle: the increment applies to the old pos, then pos advances.
- o_dp (registered, combinational from mode/pos state):
  - RUN: 000000.
  - SET: SEC = 000011, MIN = 001100, HOUR = 110000.
- All outputs are registered. Field values never exceed their MAX.
- Reset mid-edit returns to RUN at 00:00:00.

Optional Feature:
Macro WATCH_ALARM_EN.
- Defined:
  - Mode cycle becomes RUN -> SET -> ALARM -> RUN. Entering ALARM forces pos = MIN.
  - pos edge toggles MIN <-> HOUR. up edge increments alarm_min / alarm_hour, modulo, no carry. Alarm registers reset to 00:00.
  - Time keeps advancing on ticks while in ALARM.
  - In ALARM, o_hour / o_min show the alarm values and o_sec = 0. o_dp: MIN = 001100, HOUR = 110000.
  - o_alarm = 1 (registered) while mode == RUN, hour == alarm_hour and min == alarm_min. It is therefore high for one full minute.
- Undefined:
  - Alarm registers and the ALARM state are absent. Mode toggles RUN <-> SET only.
  - o_alarm is tied to 0, and o_mode never reads 2.

Test Plan:
1. Reset, then 61 i_tick pulses -> o_min = 1, o_sec = 1, o_hour = 0, o_dp = 000000, o_mode = 0.
2. Preload to 23:59:58 via SET (pos/up edges), return to RUN, apply 2 ticks -> 00:00:00 and o_day_pulse high exactly one clk on the second tick's update.
3. In SET with pos = MIN at min = 59, one up edge -> min = 0 and hour unchanged. 5 ticks during SET -> sec unchanged. o_dp = 001100.
4. Hold i_sw_up high for 100 clks in SET -> exactly one increment. Hold i_sw_mode high through reset release -> mode stays RUN.
5. Mode edge and up edge in the same cycle while in RUN -> mode = SET, pos = SEC, sec unchanged. Tick and SET->RUN mode edge in the same cycle -> sec unchanged.
6. With WATCH_ALARM_EN: set alarm 00:02, run 120 ticks from 00:00:00 -> o_alarm rises at 00:02:00, stays high through 00:02:59, falls at 00:03:00. In ALARM, o_sec = 0 and o_mode = 2.
